instr_queue: RTL and testbench

Circular FIFO of decoded instructions between the decode stage and rename/dispatch. It accepts one `instruction_info_reg_t` per cycle from decode and presents the oldest entry to dispatch through a valid/ready handshake. It decouples fetch/decode from backend stalls and is emptied in one cycle on a pipeline flush (branch mispredict or jump redirect).

---
 rtl/rv32i_types.sv | 20 ++
 rtl/instr_queue.sv | 68 ++++++
 tb/tb_instr_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types. Holds the decoded-instruction record that moves from
// decode to rename/dispatch, and the instruction queue depth.
package rv32i_types;

   localparam int unsigned IQ_DEPTH = 16;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd_addr;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] imm;
   } instruction_info_reg_t;

endpackage

// File: rtl/instr_queue.sv
// Circular FIFO of decoded instructions between decode and rename/dispatch.
// First-word-fall-through from flop storage; single-cycle flush; async active-low reset.
module instr_queue
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     flush,
   input  logic                                     enq_valid,
   input  logic [$bits(instruction_info_reg_t)-1:0] enq_data,
   output logic                                     enq_ready,
   output logic                                     deq_valid,
   output logic [$bits(instruction_info_reg_t)-1:0] deq_data,
   input  logic                                     deq_ready,
   output logic [$clog2(DEPTH):0]                   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = $bits(instruction_info_reg_t);

   // Pointers carry one extra wrap bit above the index to tell full from empty.
   logic [AW:0]   r_head;
   logic [AW:0]   r_tail;
   logic [DW-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_enq_fire;
   logic w_deq_fire;

   always_comb begin
      w_empty    = (r_head == r_tail);
      w_full     = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
      w_enq_fire = enq_valid && !w_full && !flush;
      w_deq_fire = !w_empty && deq_ready && !flush;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_enq_fire) r_tail <= r_tail + 1'b1;
         if (w_deq_fire) r_head <= r_head + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_enq_fire) begin
         r_mem[r_tail[AW-1:0]] <= enq_data;
      end
   end

   always_comb begin
      enq_ready = !w_full;
      deq_valid = !w_empty;
      deq_data  = r_mem[r_head[AW-1:0]];
      count     = r_tail - r_head;
   end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue: reset, fill, drain, wrap with concurrent
// traffic, full-with-dequeue, flush priority and asynchronous reset mid-operation.
module tb_instr_queue;
   import rv32i_types::*;

   localparam int IW = $bits(instruction_info_reg_t);

   logic          clk;
   logic          rst;
   logic          flush;
   logic          enq_valid;
   logic [IW-1:0] enq_data;
   logic          enq_ready;
   logic          deq_valid;
   logic [IW-1:0] deq_data;
   logic          deq_ready;
   logic [4:0]    count;

   instruction_info_reg_t deq_s;
   assign deq_s = deq_data;

   int n_vec = 0;
   int n_bad = 0;

   instr_queue #(.DEPTH(IQ_DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_data  (enq_data),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_data  (deq_data),
      .deq_ready (deq_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mk(input logic [31:0] inst);
      instruction_info_reg_t s;
      s          = '0;
      s.valid    = 1'b1;
      s.inst     = inst;
      s.pc       = inst << 2;
      s.rd_addr  = inst[4:0];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
      #1;
      repeat (2) tick();
      n_vec++;
      if (count !== 5'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1 || deq_data !== '0) begin
         $display("FAIL reset_in: count=%0d deq_valid=%b enq_ready=%b data=%h want 0/0/1/0",
                  count, deq_valid, enq_ready, deq_data);
         n_bad++;
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      n_vec++;
      if (count !== 5'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1 || deq_data !== '0) begin
         $display("FAIL reset_idle: count=%0d deq_valid=%b enq_ready=%b data=%h want 0/0/1/0",
                  count, deq_valid, enq_ready, deq_data);
         n_bad++;
      end
   endtask

   task automatic test_fill();
      for (int k = 0; k < 16; k++) begin
         enq_valid = 1'b1;
         enq_data  = mk(32'h13 + k);
         tick();
         n_vec++;
         if (count !== 5'(k + 1)) begin
            $display("FAIL fill_count[%0d]: got %0d want %0d", k, count, k + 1);
            n_bad++;
         end
      end
      n_vec++;
      if (enq_ready !== 1'b0) begin
         $display("FAIL fill_full_ready: got %b want 0", enq_ready);
         n_bad++;
      end
      enq_data = mk(32'h23);
      tick();
      n_vec++;
      if (count !== 5'd16 || deq_s.inst !== 32'h13) begin
         $display("FAIL fill_17th_refused: count=%0d head=%h want 16/00000013", count, deq_s.inst);
         n_bad++;
      end
      enq_valid = 1'b0;
   endtask

   task automatic test_drain();
      deq_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         n_vec++;
         if (deq_valid !== 1'b1 || deq_s.inst !== 32'h13 + k) begin
            $display("FAIL drain_order[%0d]: valid=%b inst=%h want 1/%h",
                     k, deq_valid, deq_s.inst, 32'h13 + k);
            n_bad++;
         end
         tick();
      end
      deq_ready = 1'b0;
      n_vec++;
      if (deq_valid !== 1'b0 || count !== 5'd0) begin
         $display("FAIL drain_empty: valid=%b count=%0d want 0/0", deq_valid, count);
         n_bad++;
      end
   endtask

   task automatic test_wrap();
      int next_in  = 0;
      int next_out = 0;
      for (int k = 0; k < 10; k++) begin
         enq_valid = 1'b1;
         enq_data  = mk(32'h100 + next_in);
         next_in++;
         tick();
      end
      n_vec++;
      if (count !== 5'd10) begin
         $display("FAIL wrap_preload: count=%0d want 10", count);
         n_bad++;
      end
      deq_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         enq_data = mk(32'h100 + next_in);
         n_vec++;
         if (deq_valid !== 1'b1 || deq_s.inst !== 32'h100 + next_out) begin
            $display("FAIL wrap_order[%0d]: valid=%b inst=%h want 1/%h",
                     c, deq_valid, deq_s.inst, 32'h100 + next_out);
            n_bad++;
         end
         tick();
         next_in++;
         next_out++;
         n_vec++;
         if (count !== 5'd10) begin
            $display("FAIL wrap_count[%0d]: got %0d want 10", c, count);
            n_bad++;
         end
      end
      enq_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_vec++;
         if (deq_valid !== 1'b1 || deq_s.inst !== 32'h100 + next_out) begin
            $display("FAIL wrap_tail[%0d]: valid=%b inst=%h want 1/%h",
                     k, deq_valid, deq_s.inst, 32'h100 + next_out);
            n_bad++;
         end
         tick();
         next_out++;
      end
      deq_ready = 1'b0;
      n_vec++;
      if (deq_valid !== 1'b0 || count !== 5'd0) begin
         $display("FAIL wrap_empty: valid=%b count=%0d want 0/0", deq_valid, count);
         n_bad++;
      end
   endtask

   task automatic test_full_simul();
      enq_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         enq_data = mk(32'h200 + k);
         tick();
      end
      enq_data  = mk(32'h2ff);
      deq_ready = 1'b1;
      n_vec++;
      if (enq_ready !== 1'b0 || count !== 5'd16) begin
         $display("FAIL full_pre: enq_ready=%b count=%0d want 0/16", enq_ready, count);
         n_bad++;
      end
      tick();
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      n_vec++;
      if (count !== 5'd15 || deq_s.inst !== 32'h201 || enq_ready !== 1'b1) begin
         $display("FAIL full_simul: count=%0d head=%h enq_ready=%b want 15/00000201/1",
                  count, deq_s.inst, enq_ready);
         n_bad++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_flush();
      enq_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         enq_data = mk(32'h300 + k);
         tick();
      end
      n_vec++;
      if (count !== 5'd7) begin
         $display("FAIL flush_pre: count=%0d want 7", count);
         n_bad++;
      end
      flush     = 1'b1;
      deq_ready = 1'b1;
      enq_data  = mk(32'h3ff);
      tick();
      flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      n_vec++;
      if (count !== 5'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
         $display("FAIL flush_prio: count=%0d valid=%b enq_ready=%b want 0/0/1",
                  count, deq_valid, enq_ready);
         n_bad++;
      end
      tick();
      n_vec++;
      if (count !== 5'd0 || deq_valid !== 1'b0) begin
         $display("FAIL flush_stays: count=%0d valid=%b want 0/0", count, deq_valid);
         n_bad++;
      end
   endtask

   task automatic test_reset_mid();
      enq_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         enq_data = mk(32'h400 + k);
         tick();
      end
      enq_valid = 1'b0;
      n_vec++;
      if (count !== 5'd5 || deq_valid !== 1'b1) begin
         $display("FAIL rstmid_pre: count=%0d valid=%b want 5/1", count, deq_valid);
         n_bad++;
      end
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (deq_valid !== 1'b0 || count !== 5'd0 || deq_data !== '0 || enq_ready !== 1'b1) begin
         $display("FAIL rstmid_async: valid=%b count=%0d data=%h enq_ready=%b want 0/0/0/1",
                  deq_valid, count, deq_data, enq_ready);
         n_bad++;
      end
      @(negedge clk);
      rst       = 1'b1;
      enq_valid = 1'b1;
      enq_data  = mk(32'h500);
      #1;
      n_vec++;
      if (deq_valid !== 1'b0) begin
         $display("FAIL no_empty_bypass: valid=%b want 0", deq_valid);
         n_bad++;
      end
      tick();
      enq_valid = 1'b0;
      n_vec++;
      if (count !== 5'd1 || deq_valid !== 1'b1 || deq_s.inst !== 32'h500) begin
         $display("FAIL first_enq_after_rst: count=%0d valid=%b inst=%h want 1/1/00000500",
                  count, deq_valid, deq_s.inst);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_full_simul();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
